// File: rtl/uart_writer.sv
// UART transmit writer: decodes CPU stores to the TX-data register and
// buffers the low byte in a 4-deep FIFO that feeds the UART transmitter.
module uart_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        store,
  input  logic [31:0] wdata,
  output logic [7:0]  DataIn,
  output logic        DataInValid,
  input  logic        DataInReady,
  output logic        TxReady,
  output logic        stall,
  output logic        isUARTStore
);

  logic [7:0] fifoMem_q [4];
  logic [1:0] wrPtr_q, wrPtr_d;
  logic [1:0] rdPtr_q, rdPtr_d;
  logic [2:0] count_q, count_d;
  logic       full, empty, push, pop;
  logic       unusedBits;

  // Only the TX-data register in the UART window is decoded; word aligned.
  assign isUARTStore = store && (addr[31:28] == 4'b1000) && (addr[3:0] == 4'b1000);
  assign unusedBits  = ^{wdata[31:8], addr[27:4]};

  assign full  = (count_q == 3'd4);
  assign empty = (count_q == 3'd0);
  assign push  = isUARTStore && !full;
  assign pop   = !empty && DataInReady;

  assign stall       = isUARTStore && full;
  assign TxReady     = !full;
  assign DataInValid = !empty;
  assign DataIn      = fifoMem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + 2'd1;
    if (pop)  rdPtr_d = rdPtr_q + 2'd1;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= 2'd0;
      rdPtr_q <= 2'd0;
      count_q <= 3'd0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; a store landing in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (push && !rst) fifoMem_q[wrPtr_q] <= wdata[7:0];
  end

endmodule

// File: tb/tb_uart_writer.sv
// Directed bench for uart_writer: a vector table for the single-cycle cases
// plus hand-written streaming and reset-mid-stream sequences.
module tb_uart_writer;

  localparam logic [31:0] UA = 32'h8000_0008;

  typedef struct {
    logic        store;
    logic [31:0] addr;
    logic [7:0]  wbyte;
    logic        ready;
    logic        expValid;
    logic        chkData;
    logic [7:0]  expData;
    logic        expTx;
    logic        expStall;
    logic        expIsU;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        store;
  logic [31:0] wdata;
  logic [7:0]  DataIn;
  logic        DataInValid;
  logic        DataInReady;
  logic        TxReady;
  logic        stall;
  logic        isUARTStore;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  uart_writer dut (
    .clk(clk), .rst(rst), .addr(addr), .store(store), .wdata(wdata),
    .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .TxReady(TxReady), .stall(stall), .isUARTStore(isUARTStore)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic st, input logic [31:0] a,
                               input logic [7:0] b, input logic rdy);
    rst         = r;
    store       = st;
    addr        = a;
    wdata       = {24'hABCDEF, b};
    DataInReady = rdy;
  endtask

  task automatic cmpBit(input string tag, input string sig, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %b expected %b", tag, sig, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic cd, input logic [7:0] ed,
                             input logic et, input logic es, input logic eu);
    cmpBit(tag, "DataInValid", DataInValid, ev);
    cmpBit(tag, "TxReady", TxReady, et);
    cmpBit(tag, "stall", stall, es);
    cmpBit(tag, "isUARTStore", isUARTStore, eu);
    if (cd) begin
      checks++;
      if (DataIn !== ed) begin
        errors++;
        $display("[TB] FAIL %s DataIn: got %h expected %h", tag, DataIn, ed);
      end
    end
  endtask

  task automatic addVec(input logic st, input logic [31:0] a, input logic [7:0] b, input logic rdy,
                        input logic ev, input logic cd, input logic [7:0] ed,
                        input logic et, input logic es, input logic eu);
    vec_t v;
    v.store = st; v.addr = a; v.wbyte = b; v.ready = rdy;
    v.expValid = ev; v.chkData = cd; v.expData = ed;
    v.expTx = et; v.expStall = es; v.expIsU = eu;
    vecs.push_back(v);
  endtask

  // Expected values describe outputs before the edge that applies the row.
  task automatic buildTable();
    addVec(0, UA, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
    addVec(1, UA, 8'h41, 1, 0, 0, 8'h00, 1, 0, 1);
    addVec(0, UA, 8'h00, 1, 1, 1, 8'h41, 1, 0, 0);
    addVec(0, UA, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0);
    addVec(1, 32'h8000_0000, 8'h99, 0, 0, 0, 8'h00, 1, 0, 0);
    addVec(1, 32'h8000_0004, 8'h98, 0, 0, 0, 8'h00, 1, 0, 0);
    addVec(1, 32'h0000_0008, 8'h97, 0, 0, 0, 8'h00, 1, 0, 0);
    addVec(0, UA, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
    addVec(1, UA, 8'h11, 0, 0, 0, 8'h00, 1, 0, 1);
    addVec(1, UA, 8'h22, 0, 1, 1, 8'h11, 1, 0, 1);
    addVec(1, UA, 8'h33, 0, 1, 1, 8'h11, 1, 0, 1);
    addVec(1, UA, 8'h44, 0, 1, 1, 8'h11, 1, 0, 1);
    addVec(1, UA, 8'h55, 0, 1, 1, 8'h11, 0, 1, 1);
    addVec(0, UA, 8'h00, 0, 1, 1, 8'h11, 0, 0, 0);
    addVec(0, UA, 8'h00, 1, 1, 1, 8'h11, 0, 0, 0);
    addVec(0, UA, 8'h00, 1, 1, 1, 8'h22, 1, 0, 0);
    addVec(0, UA, 8'h00, 1, 1, 1, 8'h33, 1, 0, 0);
    addVec(0, UA, 8'h00, 1, 1, 1, 8'h44, 1, 0, 0);
    addVec(0, UA, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
    addVec(1, UA, 8'hA1, 0, 0, 0, 8'h00, 1, 0, 1);
    addVec(1, UA, 8'hA2, 0, 1, 1, 8'hA1, 1, 0, 1);
    addVec(1, UA, 8'hA3, 0, 1, 1, 8'hA1, 1, 0, 1);
    addVec(1, 32'h8ABC_DE08, 8'hA4, 0, 1, 1, 8'hA1, 1, 0, 1);
    addVec(1, UA, 8'h66, 1, 1, 1, 8'hA1, 0, 1, 1);
    addVec(1, UA, 8'h66, 0, 1, 1, 8'hA2, 1, 0, 1);
    addVec(0, UA, 8'h00, 1, 1, 1, 8'hA2, 0, 0, 0);
    addVec(0, UA, 8'h00, 1, 1, 1, 8'hA3, 1, 0, 0);
    addVec(0, UA, 8'h00, 1, 1, 1, 8'hA4, 1, 0, 0);
    addVec(0, UA, 8'h00, 1, 1, 1, 8'h66, 1, 0, 0);
    addVec(0, UA, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
  endtask

  initial begin
    int sent, recvd, mcount;
    logic st, rdy, doPush, doPop;

    buildTable();
    applyStimulus(1, 0, UA, 8'h00, 0);
    @(posedge clk); #1;
    checkOutput("in_reset", 0, 0, 8'h00, 1, 0, 0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].store, vecs[i].addr, vecs[i].wbyte, vecs[i].ready);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].chkData, vecs[i].expData,
                  vecs[i].expTx, vecs[i].expStall, vecs[i].expIsU);
      @(posedge clk); #1;
    end

    // Streaming across pointer wrap with a toggling ready and CPU replay on stall.
    sent = 0; recvd = 0; mcount = 0;
    for (int cyc = 0; cyc < 80 && recvd < 10; cyc++) begin
      st  = (sent < 10);
      rdy = (cyc % 2 == 1);
      applyStimulus(0, st, UA, 8'(sent + 1), rdy);
      #1;
      checkOutput($sformatf("stream%0d", cyc), mcount != 0, mcount != 0, 8'(recvd + 1),
                  mcount != 4, st && (mcount == 4), st);
      doPush = st && (mcount != 4);
      doPop  = (mcount != 0) && rdy;
      if (doPush) sent++;
      if (doPop) recvd++;
      mcount = mcount + (doPush ? 1 : 0) - (doPop ? 1 : 0);
      @(posedge clk); #1;
    end
    checks++;
    if (recvd != 10 || sent != 10) begin
      errors++;
      $display("[TB] FAIL stream_total: got sent %0d recvd %0d expected 10 and 10", sent, recvd);
    end

    // Reset mid-stream: buffered bytes and the reset-cycle store are discarded.
    applyStimulus(0, 1, UA, 8'h31, 0); @(posedge clk); #1;
    applyStimulus(0, 1, UA, 8'h32, 0); @(posedge clk); #1;
    applyStimulus(0, 1, UA, 8'h33, 0); @(posedge clk); #1;
    applyStimulus(0, 0, UA, 8'h00, 0); #1;
    checkOutput("pre_reset", 1, 1, 8'h31, 1, 0, 0);
    applyStimulus(1, 1, UA, 8'h5A, 1); @(posedge clk); #1;
    applyStimulus(0, 0, UA, 8'h00, 0); #1;
    checkOutput("post_reset", 0, 0, 8'h00, 1, 0, 0);
    applyStimulus(0, 1, UA, 8'h7E, 0); #1;
    checkOutput("first_store", 0, 0, 8'h00, 1, 0, 1);
    @(posedge clk); #1;
    applyStimulus(0, 0, UA, 8'h00, 1); #1;
    checkOutput("only_byte", 1, 1, 8'h7E, 1, 0, 0);
    @(posedge clk); #1;
    checkOutput("drained", 0, 0, 8'h00, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_writer.md
UART_WRITER -- requirements
Module: uart_writer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock for all state.
REQ-002 SHALL have rst input 1: synchronous, active-high reset sampled on the clk rising edge.
REQ-003 SHALL have addr input 32: CPU store address.
REQ-004 SHALL have store input 1: active-high store enable for the current cycle.
REQ-005 SHALL have wdata input 32: store data; only wdata[7:0] is used.
REQ-006 SHALL have DataIn output 8: byte presented to the UART transmitter.
REQ-007 SHALL have DataInValid output 1: DataIn holds a valid byte.
REQ-008 SHALL have DataInReady input 1: the UART transmitter accepts a byte this cycle.
REQ-009 SHALL have TxReady output 1: buffer can accept a store; feeds bit 0 of the UART control word.
REQ-010 SHALL have stall output 1: the CPU must hold and replay the current store.
REQ-011 SHALL have isUARTStore output 1: the current cycle is a store to the UART transmit-data address.

Function
REQ-012 SHALL decode isUARTStore = store && addr[31:28]==4'b1000 && addr[3:0]==4'b1000; addr[1:0] must be 0.
REQ-013 SHALL ignore stores to any other 0x8xxxxxxx offset, including control 0x0 and receive-data 0x4: no push and no stall.
REQ-014 SHALL buffer bytes in a 4-entry x 8-bit FIFO using 2-bit rd/wr pointers and a 3-bit count (0..4).
REQ-015 SHALL compute full = (count==4) and empty = (count==0), both combinationally from registered state.
REQ-016 SHALL push wdata[7:0] at wr_ptr on the rising edge when isUARTStore && !full, then increment wr_ptr modulo 4.
REQ-017 SHALL drive stall = isUARTStore && full combinationally; a stalled store SHALL NOT be written and SHALL NOT alter any state.
REQ-018 SHALL drive DataInValid = !empty and DataIn = fifo[rd_ptr], both taken from registered state with no combinational path from store/wdata.
REQ-019 SHALL pop on the rising edge when DataInValid && DataInReady, then increment rd_ptr modulo 4.
REQ-020 SHALL hold DataIn stable while DataInValid=1 and DataInReady=0.
REQ-021 SHALL apply both push and pop in the same edge when both occur; count is unchanged and the pointers advance independently.
REQ-022 SHALL NOT accept a push while full, even if a pop occurs in the same cycle; stall=1 that cycle and the store is accepted on replay.
REQ-023 SHALL NOT give a push while empty same-cycle bypass: the byte appears on DataIn with DataInValid=1 on the following cycle (latency 1).
REQ-024 SHALL drive TxReady = !full.
REQ-025 SHALL emit bytes in store order; pointer wrap from 3 to 0 SHALL NOT reorder or lose data.
REQ-026 SHALL NOT let count overflow above 4 or underflow below 0 under any input combination.

Reset
REQ-027 SHALL clear rd_ptr, wr_ptr and count to 0 on a clk edge with rst=1; FIFO data contents are don't-care.
REQ-028 SHALL hold the following outputs during and after reset: DataInValid=0, TxReady=1, stall=0 (absent a store), DataIn don't-care.
REQ-029 SHALL discard buffered bytes on reset mid-operation; a store in the reset cycle is discarded, and a pop in that cycle has no effect.
REQ-030 SHALL take the first store after rst deasserts normally.

Verification
REQ-031 SHALL cover single byte: store 0x80000008, wdata=0x00000041, DataInReady=1 -> next cycle DataInValid=1 and DataIn=0x41; following cycle DataInValid=0.
REQ-032 SHALL cover fill to full: DataInReady=0, stores 0x11,0x22,0x33,0x44 -> TxReady=0; a fifth store 0x55 gives stall=1 with count still 4; raise DataInReady -> bytes drain as 0x11,0x22,0x33,0x44 in order.
REQ-033 SHALL cover full with simultaneous pop: FIFO full, DataInReady=1, store 0x66 -> stall=1, one byte popped, count=3; replayed store is accepted with stall=0 and count=4.
REQ-034 SHALL cover concurrent push/pop and wrap: stream 10 bytes 0x01..0x0A with DataInReady toggling every cycle -> output sequence is exactly 0x01..0x0A with no drop or duplicate across pointer wrap.
REQ-035 SHALL cover address filtering: stores to 0x80000000, 0x80000004 and 0x00000008 -> no push, stall=0, DataInValid stays 0.
REQ-036 SHALL cover reset mid-stream: 3 bytes buffered, rst=1 for one cycle -> DataInValid=0 and TxReady=1 the next cycle; the next store 0x7E is the only byte emitted.
